// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - shares single-port data memory between CPU MEM stage and debug loader
// Optional DMEM_ARB_RR_EN: strict round-robin instead of CPU priority with starvation override.
module dmem_arbiter #(
    parameter int MEM_LAT      = 1,
    parameter int STARVE_LIMIT = 8,
    parameter int AW           = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [31:0]   cpu_wdata,
    input  logic [3:0]    cpu_wmask,
    output logic          cpu_gnt,
    output logic          cpu_done,
    output logic [31:0]   cpu_rdata,
    output logic          cpu_stall,
    input  logic          dbg_req,
    input  logic          dbg_we,
    input  logic [AW-1:0] dbg_addr,
    input  logic [31:0]   dbg_wdata,
    input  logic [3:0]    dbg_wmask,
    output logic          dbg_gnt,
    output logic          dbg_done,
    output logic [31:0]   dbg_rdata,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [31:0]   mem_wdata,
    output logic [3:0]    mem_wmask,
    input  logic [31:0]   mem_rdata
);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_BUSY = 1'b1;
    localparam logic [2:0] LAT    = 3'(MEM_LAT);

    logic [0:0] r_state;
    logic [2:0] r_cnt;
    logic       r_owner;
    logic       r_owner_we;

    logic w_done_slot;
    logic w_arb;
    logic w_pick_cpu;
    logic w_pick_dbg;

    // Grants and done are suppressed while rst is high so nothing is issued that reset would drop.
    assign w_done_slot = ~rst & (r_state == S_BUSY) & (r_cnt == LAT);
    assign w_arb       = ~rst & ((r_state == S_IDLE) | (r_cnt == LAT));

`ifdef DMEM_ARB_RR_EN
    logic r_last_dbg;

    assign w_pick_cpu = cpu_req & (~dbg_req | r_last_dbg);
    assign w_pick_dbg = dbg_req & ~w_pick_cpu;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_last_dbg <= 1'b1;
        end else if (cpu_gnt) begin
            r_last_dbg <= 1'b0;
        end else if (dbg_gnt) begin
            r_last_dbg <= 1'b1;
        end
    end
`else
    localparam logic [7:0] SLIM = 8'(STARVE_LIMIT);
    logic [7:0] r_dbg_wait;

    assign w_pick_dbg = dbg_req & ((r_dbg_wait >= SLIM) | ~cpu_req);
    assign w_pick_cpu = cpu_req & ~w_pick_dbg;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_dbg_wait <= 8'd0;
        end else if (dbg_req & ~dbg_gnt) begin
            r_dbg_wait <= (r_dbg_wait == 8'hFF) ? 8'hFF : r_dbg_wait + 8'd1;
        end else begin
            r_dbg_wait <= 8'd0;
        end
    end
`endif

    assign cpu_gnt = w_arb & w_pick_cpu;
    assign dbg_gnt = w_arb & w_pick_dbg;

    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = 32'd0;
        mem_wmask = 4'd0;
        if (cpu_gnt) begin
            mem_en    = 1'b1;
            mem_we    = cpu_we;
            mem_addr  = cpu_addr;
            mem_wdata = cpu_wdata;
            mem_wmask = cpu_wmask;
        end else if (dbg_gnt) begin
            mem_en    = 1'b1;
            mem_we    = dbg_we;
            mem_addr  = dbg_addr;
            mem_wdata = dbg_wdata;
            mem_wmask = dbg_wmask;
        end
    end

    assign cpu_done  = w_done_slot & ~r_owner;
    assign dbg_done  = w_done_slot & r_owner;
    assign cpu_rdata = (cpu_done & ~r_owner_we) ? mem_rdata : 32'd0;
    assign dbg_rdata = (dbg_done & ~r_owner_we) ? mem_rdata : 32'd0;
    assign cpu_stall = cpu_req & ~cpu_done;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_cnt      <= 3'd0;
            r_owner    <= 1'b0;
            r_owner_we <= 1'b0;
        end else if (cpu_gnt | dbg_gnt) begin
            r_state    <= S_BUSY;
            r_cnt      <= 3'd1;
            r_owner    <= dbg_gnt;
            r_owner_we <= dbg_gnt ? dbg_we : cpu_we;
        end else if (r_state == S_BUSY) begin
            if (r_cnt == LAT) begin
                r_state <= S_IDLE;
                r_cnt   <= 3'd0;
            end else begin
                r_cnt <= r_cnt + 3'd1;
            end
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - directed checks of dmem_arbiter at MEM_LAT 1, 2 and 3
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_req, cpu_we, dbg_req, dbg_we;
    logic [31:0] cpu_addr, cpu_wdata, dbg_addr, dbg_wdata;
    logic [3:0]  cpu_wmask, dbg_wmask;

    logic        cpu_gnt [3];
    logic        cpu_done [3];
    logic        cpu_stall [3];
    logic        dbg_gnt [3];
    logic        dbg_done [3];
    logic        mem_en [3];
    logic        mem_we [3];
    logic [31:0] cpu_rdata [3];
    logic [31:0] dbg_rdata [3];
    logic [31:0] mem_addr [3];
    logic [31:0] mem_wdata [3];
    logic [3:0]  mem_wmask [3];
    logic [31:0] mem_rdata [3];

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    // Instance g runs with MEM_LAT = g+1 and owns a private memory model.
    for (genvar g = 0; g < 3; g++) begin : g_dut
        logic [31:0] mem [0:255];
        logic [31:0] pipe [0:g];

        initial begin
            for (int i = 0; i < 256; i++) mem[i] = 32'd0;
            mem[4] = 32'hDEADBEEF;
            mem[8] = 32'hAABBCCDD;
        end

        always @(posedge clk) begin
            if (mem_en[g] & mem_we[g]) begin
                for (int b = 0; b < 4; b++)
                    if (mem_wmask[g][b]) mem[mem_addr[g][9:2]][8*b +: 8] <= mem_wdata[g][8*b +: 8];
            end
            pipe[0] <= (mem_en[g] & ~mem_we[g]) ? mem[mem_addr[g][9:2]] : 32'd0;
            for (int i = 1; i <= g; i++) pipe[i] <= pipe[i-1];
        end

        assign mem_rdata[g] = pipe[g];

        dmem_arbiter #(.MEM_LAT(g + 1), .STARVE_LIMIT(8), .AW(32)) u_dut (
            .clk(clk), .rst(rst),
            .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
            .cpu_wdata(cpu_wdata), .cpu_wmask(cpu_wmask),
            .cpu_gnt(cpu_gnt[g]), .cpu_done(cpu_done[g]), .cpu_rdata(cpu_rdata[g]),
            .cpu_stall(cpu_stall[g]),
            .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr),
            .dbg_wdata(dbg_wdata), .dbg_wmask(dbg_wmask),
            .dbg_gnt(dbg_gnt[g]), .dbg_done(dbg_done[g]), .dbg_rdata(dbg_rdata[g]),
            .mem_en(mem_en[g]), .mem_we(mem_we[g]), .mem_addr(mem_addr[g]),
            .mem_wdata(mem_wdata[g]), .mem_wmask(mem_wmask[g]), .mem_rdata(mem_rdata[g])
        );
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_cpu(input logic req, input logic we, input logic [31:0] a,
                           input logic [31:0] d, input logic [3:0] m);
        cpu_req = req; cpu_we = we; cpu_addr = a; cpu_wdata = d; cpu_wmask = m;
    endtask

    task automatic set_dbg(input logic req, input logic we, input logic [31:0] a,
                           input logic [31:0] d, input logic [3:0] m);
        dbg_req = req; dbg_we = we; dbg_addr = a; dbg_wdata = d; dbg_wmask = m;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        set_cpu(0, 0, 0, 0, 0);
        set_dbg(0, 0, 0, 0, 0);
        cyc();
        cyc();
        rst = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        do_reset();

        // Reset state with no requests
        @(negedge clk);
        for (int g = 0; g < 3; g++) begin
            chk("rst_cpu_gnt", {31'd0, cpu_gnt[g]}, 32'd0);
            chk("rst_mem_en", {31'd0, mem_en[g]}, 32'd0);
            chk("rst_mem_addr", mem_addr[g], 32'd0);
            chk("rst_dones", {30'd0, cpu_done[g], dbg_done[g]}, 32'd0);
        end

        // MEM_LAT=1 CPU load of 0x10
        cyc();
        set_cpu(1, 0, 32'h10, 0, 4'hF);
        @(negedge clk);
        chk("l1_cpu_gnt", {31'd0, cpu_gnt[0]}, 32'd1);
        chk("l1_mem_en", {31'd0, mem_en[0]}, 32'd1);
        chk("l1_mem_addr", mem_addr[0], 32'h10);
        chk("l1_mem_we", {31'd0, mem_we[0]}, 32'd0);
        chk("l1_stall_t", {31'd0, cpu_stall[0]}, 32'd1);
        cyc();
        set_cpu(0, 0, 0, 0, 0);
        @(negedge clk);
        chk("l1_cpu_done", {31'd0, cpu_done[0]}, 32'd1);
        chk("l1_cpu_rdata", cpu_rdata[0], 32'hDEADBEEF);
        chk("l1_stall_t1", {31'd0, cpu_stall[0]}, 32'd0);
        chk("l1_mem_en_t1", {31'd0, mem_en[0]}, 32'd0);

        // MEM_LAT=2 simultaneous stores: CPU first, DBG at t+2
        do_reset();
        set_cpu(1, 1, 32'h40, 32'h11111111, 4'hF);
        set_dbg(1, 1, 32'h44, 32'h22222222, 4'h5);
        @(negedge clk);
        chk("c2_cpu_gnt", {31'd0, cpu_gnt[1]}, 32'd1);
        chk("c2_dbg_gnt_t", {31'd0, dbg_gnt[1]}, 32'd0);
        chk("c2_mem_we_t", {31'd0, mem_we[1]}, 32'd1);
        chk("c2_wmask_t", {28'd0, mem_wmask[1]}, 32'hF);
        chk("c2_wdata_t", mem_wdata[1], 32'h11111111);
        cyc();
        set_cpu(0, 0, 0, 0, 0);
        @(negedge clk);
        chk("c2_idle_t1", {29'd0, mem_en[1], dbg_gnt[1], cpu_done[1]}, 32'd0);
        cyc();
        @(negedge clk);
        chk("c2_cpu_done", {31'd0, cpu_done[1]}, 32'd1);
        chk("c2_cpu_rdata_st", cpu_rdata[1], 32'd0);
        chk("c2_dbg_gnt", {31'd0, dbg_gnt[1]}, 32'd1);
        chk("c2_mem_addr", mem_addr[1], 32'h44);
        chk("c2_mem_we", {31'd0, mem_we[1]}, 32'd1);
        chk("c2_wmask", {28'd0, mem_wmask[1]}, 32'h5);
        cyc();
        set_dbg(0, 0, 0, 0, 0);
        @(negedge clk);
        chk("c2_dbg_done_t3", {31'd0, dbg_done[1]}, 32'd0);
        cyc();
        @(negedge clk);
        chk("c2_dbg_done", {31'd0, dbg_done[1]}, 32'd1);
        chk("c2_dbg_rdata_st", dbg_rdata[1], 32'd0);

        // MEM_LAT=1 CPU partial store then DBG load of the same word
        do_reset();
        set_cpu(1, 1, 32'h20, 32'h12345678, 4'b0011);
        @(negedge clk);
        chk("sl_cpu_gnt", {31'd0, cpu_gnt[0]}, 32'd1);
        cyc();
        set_cpu(0, 0, 0, 0, 0);
        @(negedge clk);
        chk("sl_cpu_done", {31'd0, cpu_done[0]}, 32'd1);
        cyc();
        set_dbg(1, 0, 32'h20, 0, 4'hF);
        @(negedge clk);
        chk("sl_dbg_gnt", {31'd0, dbg_gnt[0]}, 32'd1);
        cyc();
        set_dbg(0, 0, 0, 0, 0);
        @(negedge clk);
        chk("sl_dbg_done", {31'd0, dbg_done[0]}, 32'd1);
        chk("sl_dbg_rdata", dbg_rdata[0], 32'hAABB5678);

        // MEM_LAT=3 load interrupted by reset at t+1
        do_reset();
        set_cpu(1, 0, 32'h10, 0, 4'hF);
        @(negedge clk);
        chk("rs_cpu_gnt", {31'd0, cpu_gnt[2]}, 32'd1);
        cyc();
        set_cpu(0, 0, 0, 0, 0);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        @(negedge clk);
        chk("rs_ctl_zero", {25'd0, cpu_gnt[2], cpu_done[2], cpu_stall[2], dbg_gnt[2],
                            dbg_done[2], mem_en[2], mem_we[2]}, 32'd0);
        chk("rs_addr_zero", mem_addr[2], 32'd0);
        chk("rs_rdata_zero", cpu_rdata[2] | dbg_rdata[2], 32'd0);
        cyc();
        set_cpu(1, 0, 32'h10, 0, 4'hF);
        @(negedge clk);
        chk("rs_regnt", {31'd0, cpu_gnt[2]}, 32'd1);
        chk("rs_done_t3", {31'd0, cpu_done[2]}, 32'd0);
        cyc();
        set_cpu(0, 0, 0, 0, 0);
        @(negedge clk);
        chk("rs_done_t4", {31'd0, cpu_done[2]}, 32'd0);
        cyc();
        @(negedge clk);
        chk("rs_done_t5", {31'd0, cpu_done[2]}, 32'd0);
        cyc();
        @(negedge clk);
        chk("rs_done_new", {31'd0, cpu_done[2]}, 32'd1);
        chk("rs_rdata_new", cpu_rdata[2], 32'hDEADBEEF);

`ifdef DMEM_ARB_RR_EN
        // Round-robin: continuous contention alternates starting with CPU
        do_reset();
        set_cpu(1, 0, 32'h10, 0, 4'hF);
        set_dbg(1, 0, 32'h20, 0, 4'hF);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk("rr_cpu_gnt", {31'd0, cpu_gnt[0]}, (k % 2 == 0) ? 32'd1 : 32'd0);
            chk("rr_dbg_gnt", {31'd0, dbg_gnt[0]}, (k % 2 == 1) ? 32'd1 : 32'd0);
            cyc();
        end
`else
        // Starvation override: DBG wins at t0+8, then waits another 8 cycles
        do_reset();
        set_cpu(1, 0, 32'h10, 0, 4'hF);
        set_dbg(1, 0, 32'h20, 0, 4'hF);
        for (int k = 0; k < 18; k++) begin
            @(negedge clk);
            chk("sv_dbg_gnt", {31'd0, dbg_gnt[0]}, (k == 8 || k == 17) ? 32'd1 : 32'd0);
            chk("sv_cpu_gnt", {31'd0, cpu_gnt[0]}, (k == 8 || k == 17) ? 32'd0 : 32'd1);
            if (k == 9) chk("sv_dbg_done", {31'd0, dbg_done[0]}, 32'd1);
            cyc();
        end
`endif
        set_cpu(0, 0, 0, 0, 0);
        set_dbg(0, 0, 0, 0, 0);
        cyc();

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
